// File: rtl/pca_registers_pkg.sv
// Shared PCA register-map bounds and the read-pointer advance rule.
package pca_registers_pkg;

  localparam logic [7:0] PCA_LOW_MAX_REG     = 8'h45;
  localparam logic [7:0] PCA_HIGH_MIN_REG    = 8'hFA;
  localparam logic [7:0] PCA_HIGH_MAX_REG    = 8'hFF;
  localparam logic [7:0] PCA_ALL_LED_MIN_REG = 8'hFA;
  localparam logic [7:0] PCA_ALL_LED_MAX_REG = 8'hFD;

  // Auto-increment walks each readable window and wraps back to MODE1.
  function automatic logic [7:0] next_ptr(input logic [7:0] p, input logic ai);
    if (!ai)                                           return p;
    else if (p == PCA_LOW_MAX_REG || p == PCA_HIGH_MAX_REG) return 8'h00;
    else                                               return p + 8'd1;
  endfunction

endpackage

// File: rtl/register_byte_mux.sv
// Selects one MSB-first register byte from the flat image; unreadable addresses return zero.
module register_byte_mux
  import pca_registers_pkg::*;
(
  input  logic [0:2047] blob,
  input  logic [7:0]    addr,
  output logic [7:0]    rd_byte
);

  logic in_low, in_high, all_led;

  always_comb begin
    in_low  = (addr <= PCA_LOW_MAX_REG);
    all_led = (addr >= PCA_ALL_LED_MIN_REG) && (addr <= PCA_ALL_LED_MAX_REG);
    in_high = (addr >= PCA_HIGH_MIN_REG) && !all_led;
    // Ascending vector: bit addr*8 lands in the MSB of the selected byte.
    rd_byte = (in_low || in_high) ? blob[{addr, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: rtl/register_reader.sv
// I2C read-side register streamer: fetches a snapshot byte at the pointer, holds it until consumed.
module register_reader
  import pca_registers_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [0:2047] register_blob_i,
  input  logic          set_addr_i,
  input  logic [7:0]    addr_i,
  input  logic          auto_increment_i,
  input  logic          read_start_i,
  input  logic          abort_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [7:0]    ptr_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0] state;
  logic [7:0] mux_byte;

  register_byte_mux u_mux (
    .blob    (register_blob_i),
    .addr    (ptr_o),
    .rd_byte (mux_byte)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      ptr_o      <= 8'h00;
      rd_data_o  <= 8'h00;
      rd_valid_o <= 1'b0;
    end else if (abort_i || set_addr_i) begin
      // Abort and address load both end any burst; a coincident load still lands.
      state      <= ST_IDLE;
      rd_valid_o <= 1'b0;
      if (set_addr_i) ptr_o <= addr_i;
    end else begin
      case (state)
        ST_IDLE: if (read_start_i) state <= ST_FETCH;
        ST_FETCH: begin
          rd_data_o  <= mux_byte;
          rd_valid_o <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: if (rd_ready_i) begin
          rd_valid_o <= 1'b0;
          ptr_o      <= next_ptr(ptr_o, auto_increment_i);
          state      <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_reader.sv
// Randomized self-checking bench for register_reader against a register-array reference model.
module tb_register_reader;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [0:2047] register_blob_i;
  logic          set_addr_i, auto_increment_i, read_start_i, abort_i, rd_ready_i;
  logic [7:0]    addr_i, rd_data_o, ptr_o;
  logic          rd_valid_o;

  logic [7:0] regs [256];
  logic [7:0] mp;
  int n_cmp = 0;
  int n_bad = 0;

  register_reader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .register_blob_i(register_blob_i),
    .set_addr_i(set_addr_i), .addr_i(addr_i), .auto_increment_i(auto_increment_i),
    .read_start_i(read_start_i), .abort_i(abort_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .ptr_o(ptr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: registers as an array, bit 0 of each octet at the highest blob index.
  task automatic rebuild_blob();
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 8; b++)
        register_blob_i[i*8 + b] = regs[i][7-b];
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] p);
    if (p <= 8'h45 || p >= 8'hFE) return regs[p];
    return 8'h00;
  endfunction

  function automatic logic [7:0] model_adv(input logic [7:0] p, input logic ai);
    if (!ai) return p;
    if (p == 8'h45 || p == 8'hFF) return 8'h00;
    return p + 8'd1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    set_addr_i = 1'b1; addr_i = a;
    tick();
    set_addr_i = 1'b0;
    mp = a;
  endtask

  task automatic start();
    read_start_i = 1'b1;
    tick();
    read_start_i = 1'b0;
  endtask

  task automatic abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  // Waits (bounded) for a byte, stalls, then consumes it. Ready noise while invalid must be harmless.
  task automatic consume(input int stall, output logic [7:0] d);
    int n = 0;
    while (rd_valid_o !== 1'b1 && n < 10) begin
      rd_ready_i = 1'($urandom_range(0, 1));
      tick();
      rd_ready_i = 1'b0;
      n++;
    end
    n_cmp++;
    if (rd_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL valid_timeout: rd_valid_o=%b required 1", rd_valid_o);
      d = 8'hxx;
    end else begin
      repeat (stall) tick();
      d = rd_data_o;
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    n_cmp += 3;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rd_valid_o); end
    if (ptr_o !== 8'h00)     begin n_bad++; $display("FAIL reset_ptr: got %h want 00", ptr_o); end
    if (rd_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rd_data_o); end
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    mp = 8'h00;
  endtask

  task automatic test_defaults();
    logic [7:0] d;
    auto_increment_i = 1'b1;
    start();
    n_cmp++;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL latency_early: valid=%b want 0", rd_valid_o); end
    tick();
    n_cmp += 2;
    if (rd_valid_o !== 1'b1) begin n_bad++; $display("FAIL latency: valid=%b want 1", rd_valid_o); end
    if (rd_data_o !== 8'h11) begin n_bad++; $display("FAIL mode1: got %h want 11", rd_data_o); end
    rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
    consume(0, d);
    n_cmp++;
    if (d !== 8'h04) begin n_bad++; $display("FAIL mode2: got %h want 04", d); end
    abort();
    n_cmp++;
    if (ptr_o !== 8'h02) begin n_bad++; $display("FAIL defaults_ptr: got %h want 02", ptr_o); end
  endtask

  task automatic test_wrap_low();
    logic [7:0] d;
    set_addr(8'h44);
    auto_increment_i = 1'b1;
    start();
    for (int k = 0; k < 3; k++) begin
      consume(k, d);
      n_cmp++;
      if (d !== model_byte(mp)) begin n_bad++; $display("FAIL wrap_byte%0d: got %h want %h", k, d, model_byte(mp)); end
      mp = model_adv(mp, 1'b1);
    end
    abort();
    n_cmp++;
    if (ptr_o !== 8'h01 || mp !== 8'h01) begin n_bad++; $display("FAIL wrap_ptr: got %h want 01", ptr_o); end
  endtask

  task automatic test_high_region();
    logic [7:0] d;
    logic [7:0] want [6];
    want = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h1E, regs[8'hFF]};
    set_addr(8'hFA);
    auto_increment_i = 1'b1;
    start();
    for (int k = 0; k < 6; k++) begin
      consume(0, d);
      n_cmp++;
      if (d !== want[k]) begin n_bad++; $display("FAIL high_byte%0d: got %h want %h", k, d, want[k]); end
    end
    abort();
    n_cmp++;
    if (ptr_o !== 8'h00) begin n_bad++; $display("FAIL high_ptr: got %h want 00", ptr_o); end
  endtask

  task automatic test_stall_snapshot();
    logic [7:0] d;
    bit torn = 0;
    regs[6] = 8'h12; rebuild_blob();
    set_addr(8'h06);
    auto_increment_i = 1'b1;
    start();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin regs[6] = 8'h34; rebuild_blob(); end
      if (rd_valid_o !== 1'b1 || rd_data_o !== 8'h12) torn = 1;
      tick();
    end
    n_cmp++;
    if (torn) begin n_bad++; $display("FAIL stall_hold: got %h/%b want 12/1", rd_data_o, rd_valid_o); end
    auto_increment_i = 1'b0;
    rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
    consume(1, d);
    n_cmp += 2;
    if (d !== 8'h34)     begin n_bad++; $display("FAIL stall_reread: got %h want 34", d); end
    if (ptr_o !== 8'h06) begin n_bad++; $display("FAIL stall_ptr_hold: got %h want 06", ptr_o); end
    abort();
  endtask

  task automatic test_abort_priority();
    logic [7:0] d;
    set_addr(8'h10);
    auto_increment_i = 1'b1;
    start(); tick();
    abort_i = 1'b1; rd_ready_i = 1'b1;
    tick();
    abort_i = 1'b0; rd_ready_i = 1'b0;
    n_cmp += 2;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", rd_valid_o); end
    if (ptr_o !== 8'h10)     begin n_bad++; $display("FAIL abort_ptr: got %h want 10", ptr_o); end
    start(); tick();
    set_addr_i = 1'b1; addr_i = 8'h08; rd_ready_i = 1'b1; read_start_i = 1'b1;
    tick();
    set_addr_i = 1'b0; rd_ready_i = 1'b0; read_start_i = 1'b0;
    tick(); tick();
    n_cmp += 2;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL setaddr_idle: valid=%b want 0", rd_valid_o); end
    if (ptr_o !== 8'h08)     begin n_bad++; $display("FAIL setaddr_ptr: got %h want 08", ptr_o); end
    start(); tick();
    abort_i = 1'b1; set_addr_i = 1'b1; addr_i = 8'h20;
    tick();
    abort_i = 1'b0; set_addr_i = 1'b0;
    n_cmp += 2;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL abortset_valid: got %b want 0", rd_valid_o); end
    if (ptr_o !== 8'h20)     begin n_bad++; $display("FAIL abortset_ptr: got %h want 20", ptr_o); end
    mp = 8'h20;
    start();
    consume(0, d);
    n_cmp++;
    if (d !== model_byte(8'h20)) begin n_bad++; $display("FAIL abortset_read: got %h want %h", d, model_byte(8'h20)); end
    abort();
  endtask

  task automatic test_random();
    logic [7:0] d, a;
    logic [7:0] edges [8];
    edges = '{8'h00, 8'h44, 8'h45, 8'h46, 8'hF9, 8'hFA, 8'hFD, 8'hFE};
    for (int it = 0; it < 30; it++) begin
      if (it % 5 == 0) begin
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        rebuild_blob();
      end
      a = ($urandom_range(0, 1) != 0) ? edges[$urandom_range(0, 7)] : 8'($urandom);
      set_addr(a);
      auto_increment_i = 1'($urandom_range(0, 1));
      start();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        consume(int'($urandom_range(0, 2)), d);
        n_cmp++;
        if (d !== model_byte(mp)) begin n_bad++; $display("FAIL rand_byte it%0d p=%h: got %h want %h", it, mp, d, model_byte(mp)); end
        mp = model_adv(mp, auto_increment_i);
      end
      abort();
      n_cmp++;
      if (ptr_o !== mp) begin n_bad++; $display("FAIL rand_ptr it%0d: got %h want %h", it, ptr_o, mp); end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] d;
    set_addr(8'h30);
    start(); tick();
    #2 rst_ni = 1'b0;
    #1;
    n_cmp += 3;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", rd_valid_o); end
    if (ptr_o !== 8'h00)     begin n_bad++; $display("FAIL rstmid_ptr: got %h want 00", ptr_o); end
    if (rd_data_o !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", rd_data_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: valid=%b want 0", rd_valid_o); end
    start();
    consume(0, d);
    n_cmp++;
    if (d !== regs[0]) begin n_bad++; $display("FAIL rstmid_first: got %h want %h", d, regs[0]); end
    abort();
  endtask

  initial begin
    set_addr_i = 0; addr_i = 0; auto_increment_i = 1; read_start_i = 0;
    abort_i = 0; rd_ready_i = 0; mp = 0;
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom_range(1, 255));
    regs[8'h00] = 8'h11;
    regs[8'h01] = 8'h04;
    regs[8'hFE] = 8'h1E;
    rebuild_blob();
    test_reset();
    test_defaults();
    test_wrap_low();
    test_high_region();
    test_stall_snapshot();
    test_abort_priority();
    test_random();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_reader.md
REGISTER_READER -- requirements
Module: register_reader

Interface
REQ-001 SHALL have ports: clk_i  in  1  system clock, all logic rising-edge.
REQ-002 SHALL have ports: rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: register_blob_i  in  [0:2047]  register image; register n occupies bits n*8 (MSB) to n*8+7 (LSB).
REQ-004 SHALL have ports: set_addr_i  in  1  one-cycle strobe; loads the read pointer from addr_i.
REQ-005 SHALL have ports: addr_i  in  8  register address for set_addr_i.
REQ-006 SHALL have ports: auto_increment_i  in  1  MODE1.AI level; 1 = advance the pointer after each consumed byte.
REQ-007 SHALL have ports: read_start_i  in  1  one-cycle strobe; begins a read burst at the current pointer.
REQ-008 SHALL have ports: abort_i  in  1  bus STOP or NACK; ends the burst.
REQ-009 SHALL have ports: rd_data_o  out  8  byte presented to the I2C transmitter.
REQ-010 SHALL have ports: rd_valid_o  out  1  rd_data_o is valid.
REQ-011 SHALL have ports: rd_ready_i  in  1  transmitter consumes the byte when rd_valid_o and rd_ready_i are both 1 on a rising edge.
REQ-012 SHALL have ports: ptr_o  out  8  current read pointer.

Function
REQ-013 SHALL implement states IDLE, FETCH and HOLD.
REQ-014 IDLE: on read_start_i, SHALL go to FETCH.
REQ-015 FETCH: SHALL take exactly one cycle, latch the byte at ptr_o into rd_data_o, set rd_valid_o=1, and go to HOLD.
REQ-016 Read latency: rd_valid_o SHALL assert on the 2nd rising edge after the read_start_i edge.
REQ-017 HOLD: rd_data_o SHALL remain stable while rd_valid_o=1 and rd_ready_i=0, even if register_blob_i changes (snapshot at FETCH, no tearing).
REQ-018 HOLD, on consume: rd_valid_o SHALL drop, the pointer SHALL update per REQ-020/021, and the state SHALL go to FETCH; the next byte is valid 2 edges after the consume edge.
REQ-019 Byte mapping: SHALL return register_blob_i[p*8 +: MSB-first octet] for p in 0x00..0x45 and 0xFE..0xFF.
REQ-020 Byte mapping: SHALL return 0x00 for p in 0x46..0xFD, which covers the unused gap and the write-only ALL_LED registers 0xFA..0xFD.
REQ-021 Pointer advance with auto_increment_i=1 (sampled on the consume edge): 0x45 SHALL go to 0x00, 0xFF SHALL go to 0x00, and any other value SHALL go to p+1.
REQ-022 Pointer advance with auto_increment_i=0: the pointer SHALL hold, so repeated reads return the same register.
REQ-023 set_addr_i in IDLE: SHALL load the pointer on the same edge.
REQ-024 set_addr_i during FETCH or HOLD: SHALL load the pointer, drop rd_valid_o and go to IDLE; set_addr_i has priority over consume and over read_start_i.
REQ-025 abort_i in any state: SHALL drop rd_valid_o and go to IDLE with the pointer unchanged.
REQ-026 abort_i together with consume: abort_i SHALL win and the pointer SHALL NOT advance.
REQ-027 abort_i together with set_addr_i: both SHALL take effect (load the pointer, go to IDLE).
REQ-028 read_start_i while not in IDLE: SHALL be ignored.
REQ-029 rd_ready_i while rd_valid_o=0: SHALL have no effect.

Reset
REQ-030 rst_ni low SHALL asynchronously force state=IDLE, pointer=0x00, rd_data_o=0x00 and rd_valid_o=0.
REQ-031 Reset asserted mid-burst SHALL discard the held byte; no partial output SHALL appear after reset release.
REQ-032 The first read after reset with no set_addr_i SHALL return register 0x00 (MODE1).

Structure
REQ-033 Address bounds SHALL come from the shared pca_registers definitions, not from local literals: PCA_LOW_MAX_REG=0x45, PCA_HIGH_MIN_REG=0xFA, PCA_HIGH_MAX_REG=0xFF, plus new constants PCA_ALL_LED_MIN_REG=0xFA and PCA_ALL_LED_MAX_REG=0xFD.
REQ-034 State encodings SHALL be localparams inside the module.
REQ-035 SHALL include one combinational sub-module, register_byte_mux: inputs blob and address, output 8-bit byte, implementing the bit-order and masking of REQ-019/020.

Verification
REQ-036 Reset defaults: reset, read_start_i, rd_ready_i=1 -> bytes MODE1=0x11, then MODE2=0x04 (AI=1), and ptr_o=0x02.
REQ-037 Wrap at 0x45: AI=1, set_addr_i 0x44, read 3 bytes -> contents of 0x44, 0x45, 0x00; ptr_o=0x01.
REQ-038 High region: set_addr_i 0xFA, AI=1, read 6 -> 0x00 x4, PRE_SCALE=0x1E, blob[0xFF]; ptr_o=0x00.
REQ-039 Stall and snapshot: rd_ready_i=0 for 10 cycles while blob[0x06] changes 0x12->0x34 -> rd_data_o stays 0x12; the next read of 0x06 after AI=0 returns 0x34.
REQ-040 Abort and priority: abort_i on a consume edge -> ptr_o unchanged and rd_valid_o=0; set_addr_i 0x08 in HOLD -> IDLE and ptr_o=0x08.
REQ-041 Reset mid-HOLD: rst_ni low with rd_valid_o=1 -> rd_valid_o=0 immediately (asynchronous) and ptr_o=0x00.
